// File: rtl/demux1to2_w4_reg_if.sv
// Handshake bundle for the registered 1-to-2 demultiplexer: one input stream, two output channels.
// Per-channel counters are present only when DEMUX_CNT_EN is defined.
interface demux1to2_w4_reg_if #(
  parameter int W = 4
`ifdef DEMUX_CNT_EN
  , parameter int CW = 8
`endif
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         y0_valid;
  logic         y0_ready;
  logic [W-1:0] y0_data;
  logic         y1_valid;
  logic         y1_ready;
  logic [W-1:0] y1_data;
`ifdef DEMUX_CNT_EN
  logic [CW-1:0] y0_count;
  logic [CW-1:0] y1_count;
`endif

  modport slave (
    input  in_valid, in_data, in_sel, y0_ready, y1_ready,
    output in_ready, y0_valid, y0_data, y1_valid, y1_data
`ifdef DEMUX_CNT_EN
    , output y0_count, y1_count
`endif
  );

  modport master (
    output in_valid, in_data, in_sel, y0_ready, y1_ready,
    input  in_ready, y0_valid, y0_data, y1_valid, y1_data
`ifdef DEMUX_CNT_EN
    , input y0_count, y1_count
`endif
  );
endinterface

// File: rtl/demux1to2_w4_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry holding slot per output channel.
// Optional per-channel accepted-word counters are enabled by defining DEMUX_CNT_EN.
module demux1to2_w4_reg #(
  parameter int W = 4
`ifdef DEMUX_CNT_EN
  , parameter int CW = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  demux1to2_w4_reg_if.slave bus
);

  logic [1:0]   vld_q, vld_d;
  logic [W-1:0] dat_q [2];
  logic [W-1:0] dat_d [2];
  logic [1:0]   y_ready;
  logic [1:0]   load;
  logic [1:0]   drain;
  logic         in_ready;

  // Only the addressed slot gates acceptance, so a stalled channel never blocks the other.
  always_comb begin
    y_ready  = {bus.y1_ready, bus.y0_ready};
    in_ready = !rst && (!vld_q[bus.in_sel] || y_ready[bus.in_sel]);
    load     = 2'b00;
    if (bus.in_valid && in_ready) load[bus.in_sel] = 1'b1;
    drain    = vld_q & y_ready;
    for (int k = 0; k < 2; k++) begin
      vld_d[k] = load[k] | (vld_q[k] & ~drain[k]);
      dat_d[k] = load[k] ? bus.in_data : dat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 2'b00;
      dat_q[0] <= '0;
      dat_q[1] <= '0;
    end else begin
      vld_q    <= vld_d;
      dat_q[0] <= dat_d[0];
      dat_q[1] <= dat_d[1];
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y0_valid = vld_q[0];
  assign bus.y0_data  = dat_q[0];
  assign bus.y1_valid = vld_q[1];
  assign bus.y1_data  = dat_q[1];

`ifdef DEMUX_CNT_EN
  logic [CW-1:0] cnt_q [2];

  // Counters track input-side transfers and wrap naturally at 2^CW.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      if (load[0]) cnt_q[0] <= cnt_q[0] + CW'(1);
      if (load[1]) cnt_q[1] <= cnt_q[1] + CW'(1);
    end
  end

  assign bus.y0_count = cnt_q[0];
  assign bus.y1_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux1to2_w4_reg.sv
// Bench for demux1to2_w4_reg: directed vector table, corner-case sequences and a
// randomized run against a queue-based channel model.
module tb_demux1to2_w4_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux1to2_w4_reg_if bus ();
  demux1to2_w4_reg #(.W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r, iv, sel;
    logic [3:0] d;
    logic       r0, r1;
    logic       eir, e0v;
    logic [3:0] e0d;
    logic       e1v;
    logic [3:0] e1d;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic r, iv, sel, input logic [3:0] d, input logic r0, r1,
                              input logic eir, e0v, input logic [3:0] e0d,
                              input logic e1v, input logic [3:0] e1d);
    vec_t v;
    v.r = r; v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
    v.eir = eir; v.e0v = e0v; v.e0d = e0d; v.e1v = e1v; v.e1d = e1d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, iv, sel, input logic [3:0] d, input logic r0, r1);
    rst = r; bus.in_valid = iv; bus.in_sel = sel; bus.in_data = d;
    bus.y0_ready = r0; bus.y1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: each channel is a FIFO of capacity one
  logic [3:0] mq0 [$];
  logic [3:0] mq1 [$];
  int         mcnt0, mcnt1;

  initial begin
    logic       r, iv, sel, r0, r1, eir, rdy;
    logic [3:0] d;
    int         sz;

    tbl[0]  = mk(1, 1, 0, 4'h9, 0, 0,  0, 0, 4'h0, 0, 4'h0);
    tbl[1]  = mk(0, 1, 0, 4'hA, 0, 0,  1, 0, 4'h0, 0, 4'h0);
    tbl[2]  = mk(0, 0, 0, 4'h0, 0, 0,  0, 1, 4'hA, 0, 4'h0);
    tbl[3]  = mk(0, 0, 0, 4'h0, 1, 0,  1, 1, 4'hA, 0, 4'h0);
    tbl[4]  = mk(0, 1, 0, 4'h3, 0, 0,  1, 0, 4'hA, 0, 4'h0);
    tbl[5]  = mk(0, 1, 0, 4'h4, 0, 0,  0, 1, 4'h3, 0, 4'h0);
    tbl[6]  = mk(0, 1, 1, 4'h5, 0, 0,  1, 1, 4'h3, 0, 4'h0);
    tbl[7]  = mk(0, 0, 0, 4'h0, 0, 0,  0, 1, 4'h3, 1, 4'h5);
    tbl[8]  = mk(0, 1, 0, 4'h7, 1, 1,  1, 1, 4'h3, 1, 4'h5);
    tbl[9]  = mk(0, 1, 0, 4'h8, 1, 0,  1, 1, 4'h7, 0, 4'h5);
    tbl[10] = mk(0, 0, 1, 4'h0, 0, 0,  1, 1, 4'h8, 0, 4'h5);

    drive(1, 1, 0, 4'h9, 0, 0);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      @(negedge clk);
      chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].eir));
      chk($sformatf("tbl%0d.y0_valid", i), 32'(bus.y0_valid), 32'(tbl[i].e0v));
      chk($sformatf("tbl%0d.y0_data",  i), 32'(bus.y0_data),  32'(tbl[i].e0d));
      chk($sformatf("tbl%0d.y1_valid", i), 32'(bus.y1_valid), 32'(tbl[i].e1v));
      chk($sformatf("tbl%0d.y1_data",  i), 32'(bus.y1_data),  32'(tbl[i].e1d));
      tick();
    end

    // full throughput on channel 1
    drive(1, 0, 1, 4'h0, 1, 1);
    tick();
    for (int i = 0; i <= 16; i++) begin
      drive(0, i < 16, 1, 4'(i), 1, 1);
      @(negedge clk);
      if (i < 16) chk($sformatf("thru%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("thru%0d.y1_valid", i), 32'(bus.y1_valid), 32'd1);
        chk($sformatf("thru%0d.y1_data", i), 32'(bus.y1_data), 32'(i - 1));
      end
      tick();
    end

    // mid-operation reset with both slots full
    drive(0, 1, 0, 4'hC, 0, 0); tick();
    drive(0, 1, 1, 4'hD, 0, 0); tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk("midrst.pre_y0_valid", 32'(bus.y0_valid), 32'd1);
    chk("midrst.pre_y1_data", 32'(bus.y1_data), 32'hD);
    tick();
    drive(1, 1, 0, 4'h6, 1, 1);
    @(negedge clk);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    drive(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk("midrst.y0_valid", 32'(bus.y0_valid), 32'd0);
    chk("midrst.y1_valid", 32'(bus.y1_valid), 32'd0);
    chk("midrst.y0_data", 32'(bus.y0_data), 32'd0);
    chk("midrst.y1_data", 32'(bus.y1_data), 32'd0);
    chk("midrst.release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

`ifdef DEMUX_CNT_EN
    // counter wrap: 256 transfers to channel 0
    drive(1, 0, 0, 4'h0, 1, 1); tick();
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 4'(i), 1, 1);
      tick();
    end
    drive(0, 0, 0, 4'h0, 1, 1);
    @(negedge clk);
    chk("wrap.y0_count", 32'(bus.y0_count), 32'd0);
    chk("wrap.y1_count", 32'(bus.y1_count), 32'd0);
    tick();
`endif

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      r   = (i == 0) || ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      d   = 4'($urandom);
      r0  = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 2) != 0);
      drive(r, iv, sel, d, r0, r1);
      @(negedge clk);
      sz  = sel ? mq1.size() : mq0.size();
      rdy = sel ? r1 : r0;
      eir = !r && (sz == 0 || rdy);
      chk("rnd.in_ready", 32'(bus.in_ready), 32'(eir));
      if (i > 0) begin
        chk("rnd.y0_valid", 32'(bus.y0_valid), 32'(mq0.size() != 0));
        chk("rnd.y1_valid", 32'(bus.y1_valid), 32'(mq1.size() != 0));
        if (mq0.size() != 0) chk("rnd.y0_data", 32'(bus.y0_data), 32'(mq0[0]));
        if (mq1.size() != 0) chk("rnd.y1_data", 32'(bus.y1_data), 32'(mq1[0]));
`ifdef DEMUX_CNT_EN
        chk("rnd.y0_count", 32'(bus.y0_count), 32'(mcnt0 % 256));
        chk("rnd.y1_count", 32'(bus.y1_count), 32'(mcnt1 % 256));
`endif
      end
      if (r) begin
        mq0.delete(); mq1.delete();
        mcnt0 = 0; mcnt1 = 0;
      end else begin
        if (mq0.size() != 0 && r0) void'(mq0.pop_front());
        if (mq1.size() != 0 && r1) void'(mq1.pop_front());
        if (iv && eir) begin
          if (sel) begin mq1.push_back(d); mcnt1++; end
          else     begin mq0.push_back(d); mcnt0++; end
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
